// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA sync generator.
// Defaults describe 640x480 @ 60 Hz driven from a 100 MHz system clock.
package vga_timing_pkg;

  // Width of the pixel_x / pixel_y coordinate buses.
  localparam int COORD_W   = 12;
  // Largest scan total that still fits in a COORD_W-bit counter.
  localparam int COORD_MAX = 1 << COORD_W;

  // Default 640x480 @ 60 Hz timing.
  localparam int DEF_CLK_DIV      = 4;
  localparam int DEF_H_DISPLAY    = 640;
  localparam int DEF_H_FRONT      = 16;
  localparam int DEF_H_SYNC       = 96;
  localparam int DEF_H_BACK       = 48;
  localparam int DEF_V_DISPLAY    = 480;
  localparam int DEF_V_FRONT      = 10;
  localparam int DEF_V_SYNC       = 2;
  localparam int DEF_V_BACK       = 33;
  localparam int DEF_SYNC_ACT_LOW = 1;

  // Legal pixel divider range.
  localparam int CLK_DIV_MIN = 1;
  localparam int CLK_DIV_MAX = 16;

  typedef logic [COORD_W-1:0] coord_t;

  // Total positions in one scan direction (visible + porches + sync).
  function automatic int scan_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

  // First position of the sync pulse.
  function automatic int sync_start(input int display, input int front);
    return display + front;
  endfunction

  // Last position of the sync pulse (inclusive).
  function automatic int sync_end(input int display, input int front,
                                  input int sync);
    return display + front + sync - 1;
  endfunction

endpackage

// File: rtl/mod_m_tick.sv
// Generic modulo-M counter that raises tick while the count sits at M-1.
// With M=1 the count never leaves zero and tick is permanently high.
module mod_m_tick #(
  parameter int M = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int W = (M > 1) ? $clog2(M) : 1;
  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] count;

  // Count 0..M-1 every clock and wrap back to zero after the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator: pixel-rate enable, horizontal/vertical scan
// counters, sync pulses, visible-area flag and line/frame strobes.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int H_DISPLAY    = DEF_H_DISPLAY,
  parameter int H_FRONT      = DEF_H_FRONT,
  parameter int H_SYNC       = DEF_H_SYNC,
  parameter int H_BACK       = DEF_H_BACK,
  parameter int V_DISPLAY    = DEF_V_DISPLAY,
  parameter int V_FRONT      = DEF_V_FRONT,
  parameter int V_SYNC       = DEF_V_SYNC,
  parameter int V_BACK       = DEF_V_BACK,
  parameter int SYNC_ACT_LOW = DEF_SYNC_ACT_LOW
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               p_tick,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOTAL = scan_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = scan_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

  // Bad timing sets must fail at elaboration rather than wrap silently.
  if (H_TOTAL > COORD_MAX || V_TOTAL > COORD_MAX) begin : g_total_check
    $error("vga_sync_gen: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d",
           H_TOTAL, V_TOTAL, COORD_MAX);
  end
  if (CLK_DIV < CLK_DIV_MIN || CLK_DIV > CLK_DIV_MAX) begin : g_div_check
    $error("vga_sync_gen: CLK_DIV=%0d outside %0d..%0d",
           CLK_DIV, CLK_DIV_MIN, CLK_DIV_MAX);
  end

  // Coordinate-width versions of the timing boundaries.
  localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
  localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
  localparam coord_t HS_FIRST = coord_t'(sync_start(H_DISPLAY, H_FRONT));
  localparam coord_t HS_LAST  = coord_t'(sync_end(H_DISPLAY, H_FRONT, H_SYNC));
  localparam coord_t VS_FIRST = coord_t'(sync_start(V_DISPLAY, V_FRONT));
  localparam coord_t VS_LAST  = coord_t'(sync_end(V_DISPLAY, V_FRONT, V_SYNC));

  // Sync level during retrace and outside it.
  localparam logic SYNC_ACTIVE = (SYNC_ACT_LOW != 0) ? 1'b0 : 1'b1;
  localparam logic SYNC_IDLE   = ~SYNC_ACTIVE;

  coord_t x_q;
  coord_t y_q;
  coord_t x_nxt;
  coord_t y_nxt;
  logic   video_on_q;
  logic   hsync_q;
  logic   vsync_q;
  logic   video_nxt;
  logic   hs_act_nxt;
  logic   vs_act_nxt;
  logic   pix_en;

  mod_m_tick #(
    .M (CLK_DIV)
  ) u_pix_div (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (pix_en)
  );

  // Next scan position: x advances on each pixel enable, y on the x wrap.
  always_comb begin
    x_nxt = x_q;
    y_nxt = y_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_nxt = '0;
        if (y_q == V_LAST) begin
          y_nxt = '0;
        end else begin
          y_nxt = y_q + coord_t'(1);
        end
      end else begin
        x_nxt = x_q + coord_t'(1);
      end
    end
  end

  // Decode from the next position so the registered flags line up with the counters.
  always_comb begin
    video_nxt  = (x_nxt < H_VIS) && (y_nxt < V_VIS);
    hs_act_nxt = (x_nxt >= HS_FIRST) && (x_nxt <= HS_LAST);
    vs_act_nxt = (y_nxt >= VS_FIRST) && (y_nxt <= VS_LAST);
  end

  // Scan counters and registered sync/visible flags, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q        <= '0;
      y_q        <= '0;
      video_on_q <= 1'b1;
      hsync_q    <= SYNC_IDLE;
      vsync_q    <= SYNC_IDLE;
    end else begin
      x_q        <= x_nxt;
      y_q        <= y_nxt;
      video_on_q <= video_nxt;
      hsync_q    <= hs_act_nxt ? SYNC_ACTIVE : SYNC_IDLE;
      vsync_q    <= vs_act_nxt ? SYNC_ACTIVE : SYNC_IDLE;
    end
  end

  assign p_tick     = pix_en;
  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign video_on   = video_on_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign line_tick  = pix_en && (x_q == H_LAST);
  assign frame_tick = line_tick && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen: a divide-by-4 active-low instance
// and a divide-by-1 active-high instance run side by side against a
// position-from-clock-count reference model.
module tb_vga_sync_gen;

  localparam int HD = 640;
  localparam int HF = 16;
  localparam int HS = 96;
  localparam int HB = 48;
  localparam int HT = HD + HF + HS + HB;
  localparam int VD = 3;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 1;
  localparam int VT = VD + VF + VS + VB;
  localparam int DIV_A = 4;
  localparam int DIV_B = 1;

  typedef struct packed {
    logic        p_tick;
    logic [11:0] x;
    logic [11:0] y;
    logic        video_on;
    logic        hsync;
    logic        vsync;
    logic        line_tick;
    logic        frame_tick;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p_tick_a, video_on_a, hsync_a, vsync_a, line_tick_a, frame_tick_a;
  logic [11:0] x_a, y_a;
  logic        p_tick_b, video_on_b, hsync_b, vsync_b, line_tick_b, frame_tick_b;
  logic [11:0] x_b, y_b;
  obs_t        obs_a, obs_b;
  int          checks = 0;
  int          failures = 0;
  int          k;

  vga_sync_gen #(
    .CLK_DIV(DIV_A), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACT_LOW(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick_a), .pixel_x(x_a), .pixel_y(y_a),
    .video_on(video_on_a), .hsync(hsync_a), .vsync(vsync_a),
    .line_tick(line_tick_a), .frame_tick(frame_tick_a)
  );

  vga_sync_gen #(
    .CLK_DIV(DIV_B), .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .SYNC_ACT_LOW(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .p_tick(p_tick_b), .pixel_x(x_b), .pixel_y(y_b),
    .video_on(video_on_b), .hsync(hsync_b), .vsync(vsync_b),
    .line_tick(line_tick_b), .frame_tick(frame_tick_b)
  );

  assign obs_a = {p_tick_a, x_a, y_a, video_on_a, hsync_a, vsync_a, line_tick_a, frame_tick_a};
  assign obs_b = {p_tick_b, x_b, y_b, video_on_b, hsync_b, vsync_b, line_tick_b, frame_tick_b};

  always #5 clk = ~clk;

  // Clock edges seen since reset was released.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  // Expected outputs after kk clock edges: position is simply kk/div pixels into the frame.
  function automatic obs_t model(input int kk, input int div, input bit act_low);
    obs_t m;
    int   pos, x, y;
    bit   pt, hs, vs;
    pos = (kk / div) % (HT * VT);
    x = pos % HT;
    y = pos / HT;
    pt = (kk % div) == (div - 1);
    hs = (x >= HD + HF) && (x < HD + HF + HS);
    vs = (y >= VD + VF) && (y < VD + VF + VS);
    m.p_tick = pt;
    m.x = 12'(x);
    m.y = 12'(y);
    m.video_on = (x < HD) && (y < VD);
    m.hsync = hs ? !act_low : act_low;
    m.vsync = vs ? !act_low : act_low;
    m.line_tick = pt && (x == HT - 1);
    m.frame_tick = m.line_tick && (y == VT - 1);
    return m;
  endfunction

  task automatic test_reset();
    obs_t exp_a, exp_b;
    int   edges;
    bit   seen;
    exp_a = {1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_b = {1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    rst_n = 1'b0;
    repeat ($urandom_range(2, 5)) @(posedge clk);
    @(negedge clk);
    checks++;
    if (obs_a !== exp_a) begin
      failures++;
      $display("[TB] FAIL reset_state_a: got %h want %h", obs_a, exp_a);
    end
    checks++;
    if (obs_b !== exp_b) begin
      failures++;
      $display("[TB] FAIL reset_state_b: got %h want %h", obs_b, exp_b);
    end
    rst_n = 1'b1;
    edges = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (x_a == 12'd1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen || edges != DIV_A) begin
      failures++;
      $display("[TB] FAIL first_advance_a: got edge %0d (seen=%0d) want edge %0d", edges, seen, DIV_A);
    end
  endtask

  task automatic test_hsync();
    obs_t ea, eb, bad_o, bad_e;
    int   errs = 0, bad_k = -1, lows = 0, xmin = 4095, xmax = -1, fall_x = -1;
    bit   prev_von = 1'b1, done = 1'b0;
    for (int i = 0; i < 4 * HT + 16; i++) begin
      @(negedge clk);
      ea = model(k, DIV_A, 1'b1);
      eb = model(k, DIV_B, 1'b0);
      if (obs_a !== ea || obs_b !== eb) begin
        if (errs == 0) begin bad_k = k; bad_o = obs_a; bad_e = ea; end
        errs++;
      end
      if (hsync_a == 1'b0) begin
        lows++;
        if (int'(x_a) < xmin) xmin = int'(x_a);
        if (int'(x_a) > xmax) xmax = int'(x_a);
      end
      if (prev_von && !video_on_a && fall_x < 0) fall_x = int'(x_a);
      prev_von = video_on_a;
      if (line_tick_a) begin done = 1'b1; break; end
    end
    checks++;
    if (!done) begin failures++; $display("[TB] FAIL hsync_line_end: got no line_tick want one within %0d clks", 4 * HT + 16); end
    checks++;
    if (errs != 0) begin failures++; $display("[TB] FAIL hsync_lockstep: got %0d errors (first k=%0d obs %h) want 0 (model %h)", errs, bad_k, bad_o, bad_e); end
    checks++;
    if (lows != HS * DIV_A) begin failures++; $display("[TB] FAIL hsync_low_clks: got %0d want %0d", lows, HS * DIV_A); end
    checks++;
    if (xmin != HD + HF || xmax != HD + HF + HS - 1) begin
      failures++;
      $display("[TB] FAIL hsync_range: got %0d..%0d want %0d..%0d", xmin, xmax, HD + HF, HD + HF + HS - 1);
    end
    checks++;
    if (fall_x != HD) begin failures++; $display("[TB] FAIL video_fall_x: got %0d want %0d", fall_x, HD); end
  endtask

  task automatic test_steady();
    obs_t ea, eb, bad_o, bad_e;
    int   n, errs = 0, bad_k = -1, last_pt = -1, bad_pt = 0, pt_n = 0;
    int   last_lt = -1, lt_n = 0, lt_gap = -1, wrap_x = -1, after_x = -1, after_y = -1, want_y = -1;
    bit   want_wrap = 1'b0;
    n = 2 * HT * DIV_A + $urandom_range(0, 400);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ea = model(k, DIV_A, 1'b1);
      eb = model(k, DIV_B, 1'b0);
      if (obs_a !== ea || obs_b !== eb) begin
        if (errs == 0) begin bad_k = k; bad_o = obs_a; bad_e = ea; end
        errs++;
      end
      if (want_wrap) begin
        after_x = int'(x_a);
        after_y = int'(y_a);
        want_wrap = 1'b0;
      end
      if (p_tick_a) begin
        if (last_pt >= 0 && k - last_pt != DIV_A) bad_pt++;
        last_pt = k;
        pt_n++;
      end
      if (line_tick_a) begin
        if (last_lt >= 0) lt_gap = k - last_lt;
        if (lt_n == 0) begin
          wrap_x = int'(x_a);
          want_y = (k / (DIV_A * HT) + 1) % VT;
          want_wrap = 1'b1;
        end
        last_lt = k;
        lt_n++;
      end
    end
    checks++;
    if (errs != 0) begin failures++; $display("[TB] FAIL steady_lockstep: got %0d errors (first k=%0d obs %h) want 0 (model %h)", errs, bad_k, bad_o, bad_e); end
    checks++;
    if (bad_pt != 0 || pt_n < 2 * HT) begin failures++; $display("[TB] FAIL p_tick_period: got %0d bad gaps over %0d ticks want 0 bad gaps", bad_pt, pt_n); end
    checks++;
    if (lt_n != 2 || lt_gap != DIV_A * HT) begin failures++; $display("[TB] FAIL line_tick_period: got %0d ticks gap %0d want 2 ticks gap %0d", lt_n, lt_gap, DIV_A * HT); end
    checks++;
    if (wrap_x != HT - 1 || after_x != 0 || after_y != want_y) begin
      failures++;
      $display("[TB] FAIL line_wrap: got x %0d -> (%0d,%0d) want x %0d -> (0,%0d)", wrap_x, after_x, after_y, HT - 1, want_y);
    end
  endtask

  task automatic test_frame_wrap();
    obs_t ea, eb, bad_o, bad_e;
    int   errs = 0, bad_k = -1, pt_n = 0, vs_n = 0, ymin = 4095, ymax = -1, lim;
    int   fx = -1, fy = -1;
    bit   seen = 1'b0, done = 1'b0;
    lim = DIV_A * HT * VT + 100;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      ea = model(k, DIV_A, 1'b1);
      eb = model(k, DIV_B, 1'b0);
      if (obs_a !== ea || obs_b !== eb) begin
        if (errs == 0) begin bad_k = k; bad_o = obs_a; bad_e = ea; end
        errs++;
      end
      if (frame_tick_a) begin seen = 1'b1; fx = int'(x_a); fy = int'(y_a); break; end
    end
    checks++;
    if (!seen || fx != HT - 1 || fy != VT - 1) begin
      failures++;
      $display("[TB] FAIL frame_tick_pos: got seen=%0d at (%0d,%0d) want (%0d,%0d)", seen, fx, fy, HT - 1, VT - 1);
    end
    @(negedge clk);
    checks++;
    if (frame_tick_a !== 1'b0 || x_a !== 12'd0 || y_a !== 12'd0) begin
      failures++;
      $display("[TB] FAIL frame_wrap: got ft=%0b (%0d,%0d) want ft=0 (0,0)", frame_tick_a, x_a, y_a);
    end
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      ea = model(k, DIV_A, 1'b1);
      eb = model(k, DIV_B, 1'b0);
      if (obs_a !== ea || obs_b !== eb) begin
        if (errs == 0) begin bad_k = k; bad_o = obs_a; bad_e = ea; end
        errs++;
      end
      if (p_tick_a) begin
        pt_n++;
        if (!vsync_a) begin
          vs_n++;
          if (int'(y_a) < ymin) ymin = int'(y_a);
          if (int'(y_a) > ymax) ymax = int'(y_a);
        end
      end
      if (frame_tick_a) begin done = 1'b1; break; end
    end
    checks++;
    if (!done || pt_n != HT * VT) begin failures++; $display("[TB] FAIL frame_period: got %0d p_ticks (done=%0d) want %0d", pt_n, done, HT * VT); end
    checks++;
    if (vs_n != HT * VS || ymin != VD + VF || ymax != VD + VF + VS - 1) begin
      failures++;
      $display("[TB] FAIL vsync_window: got %0d ticks y %0d..%0d want %0d ticks y %0d..%0d", vs_n, ymin, ymax, HT * VS, VD + VF, VD + VF + VS - 1);
    end
    checks++;
    if (errs != 0) begin failures++; $display("[TB] FAIL frame_lockstep: got %0d errors (first k=%0d obs %h) want 0 (model %h)", errs, bad_k, bad_o, bad_e); end
  endtask

  task automatic test_variant();
    obs_t eb, bad_o, bad_e;
    int   errs = 0, bad_k = -1, clks = 0, pt_low = 0, hs_hi = 0, xmin = 4095, xmax = -1, lim;
    bit   seen = 1'b0, done = 1'b0;
    lim = HT * VT + 16;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (frame_tick_b) begin seen = 1'b1; break; end
    end
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      clks++;
      eb = model(k, DIV_B, 1'b0);
      if (obs_b !== eb) begin
        if (errs == 0) begin bad_k = k; bad_o = obs_b; bad_e = eb; end
        errs++;
      end
      if (!p_tick_b) pt_low++;
      if (hsync_b) begin
        hs_hi++;
        if (int'(x_b) < xmin) xmin = int'(x_b);
        if (int'(x_b) > xmax) xmax = int'(x_b);
      end
      if (frame_tick_b) begin done = 1'b1; break; end
    end
    checks++;
    if (!seen || !done || clks != HT * VT) begin failures++; $display("[TB] FAIL variant_frame_clks: got %0d (seen=%0d done=%0d) want %0d", clks, seen, done, HT * VT); end
    checks++;
    if (pt_low != 0) begin failures++; $display("[TB] FAIL variant_p_tick: got %0d low clks want 0", pt_low); end
    checks++;
    if (hs_hi != HS * VT || xmin != HD + HF || xmax != HD + HF + HS - 1) begin
      failures++;
      $display("[TB] FAIL variant_hsync: got %0d high x %0d..%0d want %0d high x %0d..%0d", hs_hi, xmin, xmax, HS * VT, HD + HF, HD + HF + HS - 1);
    end
    checks++;
    if (errs != 0) begin failures++; $display("[TB] FAIL variant_lockstep: got %0d errors (first k=%0d obs %h) want 0 (model %h)", errs, bad_k, bad_o, bad_e); end
  endtask

  task automatic test_async_reset();
    obs_t ea, eb, exp_a, exp_b, bad_o, bad_e;
    int   errs = 0, bad_k = -1, x4 = -1, y4 = -1;
    exp_a = {1'b0, 12'd0, 12'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_b = {1'b1, 12'd0, 12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat ($urandom_range(300, 3000)) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_a !== exp_a) begin failures++; $display("[TB] FAIL async_reset_a: got %h want %h", obs_a, exp_a); end
    checks++;
    if (obs_b !== exp_b) begin failures++; $display("[TB] FAIL async_reset_b: got %h want %h", obs_b, exp_b); end
    repeat ($urandom_range(1, 3)) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      ea = model(k, DIV_A, 1'b1);
      eb = model(k, DIV_B, 1'b0);
      if (obs_a !== ea || obs_b !== eb) begin
        if (errs == 0) begin bad_k = k; bad_o = obs_a; bad_e = ea; end
        errs++;
      end
      if (i == DIV_A - 1) begin x4 = int'(x_a); y4 = int'(y_a); end
    end
    checks++;
    if (x4 != 1 || y4 != 0) begin failures++; $display("[TB] FAIL restart_pos: got (%0d,%0d) after %0d clks want (1,0)", x4, y4, DIV_A); end
    checks++;
    if (errs != 0) begin failures++; $display("[TB] FAIL restart_lockstep: got %0d errors (first k=%0d obs %h) want 0 (model %h)", errs, bad_k, bad_o, bad_e); end
  endtask

  initial begin
    test_reset();
    test_hsync();
    test_steady();
    test_frame_wrap();
    test_variant();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
